axi_lite_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file: NUM_REGS registers of DATA_WIDTH bits.
- Adds the following:
  - Byte-strobe writes.
  - Independent AW/W acceptance in either order.
  - Back-pressured B and R channels.
  - SLVERR on out-of-range addresses.
  - Per-register write-strobe outputs.
- Sits between the AXI-Lite interconnect and peripheral control logic; register contents are exported in parallel.

---
 rtl/axi_lite_regfile.sv | 175 +++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile
// Brief    : AXI4-Lite slave register file with byte strobes, SLVERR on
//            out-of-range accesses, parallel export and per-register pulses.
// Revision : 1.0
// ============================================================================
module axi_lite_regfile #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int         c_STRB_W      = DATA_WIDTH / 8;
    localparam int         c_OFF_W       = $clog2(c_STRB_W);
    localparam int         c_IDX_W       = ADDR_WIDTH - c_OFF_W;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_aw_full;
    logic [c_IDX_W-1:0]    r_aw_idx;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [c_STRB_W-1:0]   r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_commit;
    logic                  w_aw_valid;
    logic                  w_ar_valid;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic [NUM_REGS-1:0]   w_aw_hit;
    logic [NUM_REGS-1:0]   w_ar_hit;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    // Byte-offset bits never select anything; only the word index matters.
    assign w_unused  = ^{1'b0, AWADDR[c_OFF_W-1:0], ARADDR[c_OFF_W-1:0]};
    assign w_ar_idx  = ARADDR[ADDR_WIDTH-1:c_OFF_W];

    assign w_awready = !r_aw_full && !r_bvalid;
    assign w_wready  = !r_w_full && !r_bvalid;
    assign w_arready = !r_rvalid;
    assign w_commit  = r_aw_full && r_w_full;

    // One-hot decode; an out-of-range index matches no register.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign w_aw_hit[gi] = (r_aw_idx == c_IDX_W'(gi));
        assign w_ar_hit[gi] = (w_ar_idx == c_IDX_W'(gi));
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end

    assign w_aw_valid = |w_aw_hit;
    assign w_ar_valid = |w_ar_hit;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_hit[i]) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            if (AWVALID && w_awready) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= AWADDR[ADDR_WIDTH-1:c_OFF_W];
            end
            if (WVALID && w_wready) begin
                r_w_full <= 1'b1;
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end
            // Address and data both held: commit and raise the response.
            if (w_commit) begin
                r_aw_full  <= 1'b0;
                r_w_full   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_aw_valid ? c_RESP_OKAY : c_RESP_SLVERR;
                r_wr_pulse <= w_aw_hit;
            end else begin
                r_wr_pulse <= '0;
                if (r_bvalid && BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < c_STRB_W; k++) begin
                    if (w_aw_hit[i] && r_w_strb[k]) begin
                        r_regs[i][k*8 +: 8] <= r_w_data[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Reads sample the register array before any same-edge commit lands.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else if (ARVALID && w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_ar_valid ? c_RESP_OKAY : c_RESP_SLVERR;
        end else if (r_rvalid && RREADY) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end
    end

    assign AWREADY  = w_awready;
    assign WREADY   = w_wready;
    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign ARREADY  = w_arready;
    assign RVALID   = r_rvalid;
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign wr_pulse = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regfile
// Brief    : Self-checking bench for axi_lite_regfile against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_regfile;

    localparam int NR = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [5:0]    AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [5:0]    ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic [255:0]  reg_out;
    logic [7:0]    wr_pulse;

    always #5 ACLK = ~ACLK;

    axi_lite_regfile #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .NUM_REGS   (NR)
    ) u_dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [NR];

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] m_packed();
        logic [255:0] p = '0;
        for (int i = 0; i < NR; i++) p[i*32 +: 32] = m_regs[i];
        return p;
    endfunction

    function automatic int m_idx(input logic [5:0] a);
        return int'(a) / 4;
    endfunction

    task automatic write_txn(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_d, input int w_d, input int hold);
        bit           aw_done = 0;
        bit           w_done  = 0;
        bit           hs_aw;
        bit           hs_w;
        int           t = 0;
        int           n = 0;
        int           idx;
        logic [31:0]  mask;
        logic [1:0]   exp_resp;
        logic [7:0]   exp_pulse;
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        BREADY = 1'b0;
        while (!(aw_done && w_done) && t < 50) begin
            AWVALID = !aw_done && (t >= aw_d);
            WVALID  = !w_done && (t >= w_d);
            hs_aw   = AWVALID && AWREADY;
            hs_w    = WVALID && WREADY;
            step();
            t++;
            aw_done |= hs_aw;
            w_done  |= hs_w;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        chk("pre_commit_bvalid", BVALID, 0);
        chk("pre_commit_regs", reg_out, m_packed());
        while (!BVALID && n < 10) begin
            step();
            n++;
        end
        chk("b_latency", n, 1);
        idx = m_idx(addr);
        if (idx < NR) begin
            mask = 32'h0;
            for (int k = 0; k < 4; k++) if (strb[k]) mask = mask + (32'hFF << (8 * k));
            m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
            exp_resp    = 2'b00;
            exp_pulse   = 8'(1 << idx);
        end else begin
            exp_resp  = 2'b10;
            exp_pulse = 8'h00;
        end
        chk("bresp", BRESP, exp_resp);
        chk("wr_pulse", wr_pulse, exp_pulse);
        chk("reg_out", reg_out, m_packed());
        for (int h = 0; h < hold; h++) begin
            step();
            chk("b_hold_valid", BVALID, 1);
            chk("b_hold_resp", BRESP, exp_resp);
            chk("b_hold_ready", {AWREADY, WREADY}, 2'b00);
            chk("b_hold_pulse", wr_pulse, 0);
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk("b_clear", BVALID, 0);
        chk("pulse_once", wr_pulse, 0);
    endtask

    task automatic read_txn(input logic [5:0] addr, input int hold);
        int          idx = m_idx(addr);
        logic [31:0] ed;
        logic [1:0]  er;
        if (idx < NR) begin
            ed = m_regs[idx];
            er = 2'b00;
        end else begin
            ed = 32'h0;
            er = 2'b10;
        end
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        chk("ar_ready", ARREADY, 1);
        step();
        ARVALID = 1'b0;
        chk("rvalid", RVALID, 1);
        chk("rdata", RDATA, ed);
        chk("rresp", RRESP, er);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("r_hold_valid", RVALID, 1);
            chk("r_hold_data", RDATA, ed);
            chk("r_hold_arready", ARREADY, 0);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        chk("r_clear", RVALID, 0);
        chk("rdata_zero", RDATA, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        ARESET  = 1'b1;
        AWADDR  = '0;
        AWVALID = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = '0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        step();
        step();
        ARESET = 1'b0;

        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_regs", reg_out, 0);
        chk("rst_pulse", wr_pulse, 0);
        chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int i = 0; i < NR; i++) read_txn(6'(i * 4), 0);

        // Same-cycle AW and W
        write_txn(6'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg2_literal", reg_out[95:64], 32'hDEADBEEF);
        read_txn(6'h08, 0);

        // W leads AW by three cycles, then a partial-strobe update
        write_txn(6'h04, 32'h12345678, 4'hF, 3, 0, 0);
        write_txn(6'h04, 32'hAABBCCDD, 4'b0101, 1, 1, 0);
        chk("strobe_literal", reg_out[63:32], 32'h12BB56DD);
        read_txn(6'h04, 0);

        // Out of range
        write_txn(6'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        read_txn(6'h20, 0);

        // Back-pressure on both response channels
        write_txn(6'h10, 32'h0BADF00D, 4'hF, 0, 1, 5);
        read_txn(6'h10, 5);

        // Read sampled on the commit edge sees the old value
        old     = m_regs[3];
        AWADDR  = 6'h0C;
        WDATA   = 32'hCAFEF00D;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        step();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARADDR  = 6'h0C;
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        chk("collide_bvalid", BVALID, 1);
        chk("collide_rdata", RDATA, old);
        m_regs[3] = 32'hCAFEF00D;
        chk("collide_regs", reg_out, m_packed());
        BREADY = 1'b1;
        RREADY = 1'b1;
        step();
        BREADY = 1'b0;
        RREADY = 1'b0;
        chk("collide_clear", {BVALID, RVALID}, 2'b00);

        // Randomized traffic, including offset bits and out-of-range indices
        for (int r = 0; r < 24; r++) begin
            write_txn(6'($urandom_range(0, 39)), $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)));
            read_txn(6'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
        end

        // Reset with a pending write address and a held read response
        AWADDR  = 6'h00;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        ARADDR  = 6'h08;
        ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        chk("pre_reset_rvalid", RVALID, 1);
        chk("pre_reset_awready", AWREADY, 0);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        chk("post_reset_valids", {BVALID, RVALID}, 2'b00);
        chk("post_reset_rdata", RDATA, 0);
        chk("post_reset_resps", {BRESP, RRESP}, 4'b0000);
        chk("post_reset_regs", reg_out, m_packed());
        chk("post_reset_pulse", wr_pulse, 0);
        chk("post_reset_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
        WDATA  = 32'h55AA55AA;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("dropped_no_b", BVALID, 0);
            step();
        end
        chk("dropped_regs", reg_out, m_packed());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
